safe_lock_actuator: RTL
=======================

# safe_lock_actuator

Consumes the decision stream from the serial code checker (`res_val`/`res_data`, one-cycle Mealy pulses) and drives the bolt solenoid of the safe. Runs the unlock hold window, waits for the door to close before relocking, counts consecutive wrong codes and enforces a timed lockout after `MAX_FAIL` failures. This is the last digital stage before the solenoid driver and the front-panel status LEDs.

## Interface
- `MAX_FAIL`, 3, consecutive failed attempts that trigger lockout (≥1)
- `UNLOCK_CYCLES`, 16, cycles `solenoid_en` is held high per accepted code (≥1, < 2^`TMR_W`)
- `LOCKOUT_CYCLES`, 64, cycles `lockout` is held high (≥1, < 2^`TMR_W`)
- `TMR_W`, 16, shared down-counter width

- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `res_val`  in  1  checker decision valid, one-cycle pulse
- `res_data`  in  1  decision: 1 = correct code, 0 = wrong code (meaningful only with `res_val`)
- `door_closed`  in  1  door switch, already synchronous to `clk`
- `solenoid_en`  out  1  bolt retracted when high
- `lockout`  out  1  lockout active
- `fail_cnt`  out  $clog2(MAX_FAIL+1)  consecutive failures since last success/lockout exit
- `state_o`  out  2  current state: 0 LOCKED, 1 UNLOCKED, 2 AJAR, 3 LOCKOUT
- `tamper`  out  1  one-cycle pulse, see Configuration

## Operation
- States: LOCKED, UNLOCKED, AJAR, LOCKOUT. One down-counter `tmr` (`TMR_W` bits) shared by UNLOCKED and LOCKOUT.
- LOCKED:
  - `res_val`&`res_data` → UNLOCKED, `tmr`←`UNLOCK_CYCLES`-1, `fail_cnt`←0.
  - `res_val`&!`res_data`: if `fail_cnt`+1 == `MAX_FAIL` → LOCKOUT, `tmr`←`LOCKOUT_CYCLES`-1, `fail_cnt`←`MAX_FAIL`; else `fail_cnt`+1, stay.
  - no `res_val` → stay.
- UNLOCKED: `tmr` decrements each cycle; at `tmr`==0 → LOCKED if `door_closed`, else AJAR. `res_val` ignored.
- AJAR: solenoid off, bolt held out mechanically by open door; → LOCKED on first cycle `door_closed`=1. `res_val` ignored.
- LOCKOUT: `tmr` decrements; at `tmr`==0 → LOCKED, `fail_cnt`←0. `res_val` ignored (unless macro enabled).
- `fail_cnt` never exceeds `MAX_FAIL`; no wrap.
- Outputs decoded from registered state: `solenoid_en` = (state==UNLOCKED), `lockout` = (state==LOCKOUT), `state_o` = state encoding.

## Timing
- Reset (async assert): state LOCKED, `tmr`=0, `fail_cnt`=0, `solenoid_en`=0, `lockout`=0, `state_o`=0, `tamper`=0. Reset mid-UNLOCKED drops the solenoid immediately.
- Latency: `res_val` sampled at edge N → state/outputs change after edge N (visible in cycle N+1).
- `solenoid_en` high for exactly `UNLOCK_CYCLES` cycles; `lockout` high for exactly `LOCKOUT_CYCLES` cycles.
- UNLOCKED expiry with `door_closed`=1 → LOCKED directly, no AJAR cycle.
- `res_val` on the same edge as a UNLOCKED/LOCKOUT exit is dropped; first honoured `res_val` is the one sampled while in LOCKED.
- `res_val` pulses on consecutive cycles each count.

## Configuration
- `SAFE_TAMPER_ALARM_EN` defined: any `res_val` sampled in LOCKOUT reloads `tmr`←`LOCKOUT_CYCLES`-1 (lockout extends) and pulses `tamper` high for one cycle, one cycle after the sample.
- Not defined: `res_val` in LOCKOUT ignored, `tamper` tied 0, lockout length fixed.

## Test plan
- Reset, `res_val`=1/`res_data`=1 one cycle, `door_closed`=1 → `solenoid_en` high 16 cycles starting next cycle, then `state_o`=0, `fail_cnt`=0.
- Correct code, `door_closed`=0 until 30 cycles later → `solenoid_en` 16 cycles, `state_o`=2 until cycle after door closes, then 0.
- Three wrong pulses (`res_data`=0) → `fail_cnt` 1,2, then `lockout` high 64 cycles, `fail_cnt`=3 during, 0 after; correct code during lockout leaves `solenoid_en`=0.
- Two wrong then one correct → `fail_cnt` 1,2,0, unlock; next two wrong → `fail_cnt` 2, no lockout.
- With `SAFE_TAMPER_ALARM_EN`: `res_val` at lockout cycle 40 → `tamper` one-cycle pulse, `lockout` stays high 64 more cycles; without macro: `tamper`=0, lockout ends at 64.
- `rstn` low in UNLOCKED cycle 5 and in LOCKOUT cycle 10 → all outputs 0 immediately, `state_o`=0 after release.

Source files
------------

// File: rtl/safe_lock_actuator.sv
// Bolt solenoid sequencer: unlock hold window, door-ajar wait, failed-attempt lockout.
// Optional `SAFE_TAMPER_ALARM_EN: decisions during lockout extend it and pulse tamper.
module safe_lock_actuator #(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned UNLOCK_CYCLES  = 16,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned TMR_W          = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            res_val,
  input  logic                            res_data,
  input  logic                            door_closed,
  output logic                            solenoid_en,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [1:0]                      state_o,
  output logic                            tamper
);

  localparam int unsigned        FW         = $clog2(MAX_FAIL + 1);
  localparam logic [TMR_W-1:0]   UNLOCK_LD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]   LOCKOUT_LD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0]      FAIL_MAX   = FW'(MAX_FAIL);
  localparam logic [FW-1:0]      FAIL_LAST  = FW'(MAX_FAIL - 1);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    AJAR     = 2'd2,
    LOCKOUT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic             solenoid_q, lockout_q;
`ifdef SAFE_TAMPER_ALARM_EN
  logic             tamper_q, tamper_d;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    fail_d   = fail_q;
`ifdef SAFE_TAMPER_ALARM_EN
    tamper_d = 1'b0;
`endif
    case (state_q)
      LOCKED: begin
        if (res_val) begin
          if (res_data) begin
            state_d = UNLOCKED;
            tmr_d   = UNLOCK_LD;
            fail_d  = '0;
          end else if (fail_q == FAIL_LAST) begin
            state_d = LOCKOUT;
            tmr_d   = LOCKOUT_LD;
            fail_d  = FAIL_MAX;
          end else begin
            fail_d  = fail_q + FW'(1);
          end
        end
      end
      UNLOCKED: begin
        if (tmr_q == '0) state_d = door_closed ? LOCKED : AJAR;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      AJAR: begin
        if (door_closed) state_d = LOCKED;
      end
      LOCKOUT: begin
`ifdef SAFE_TAMPER_ALARM_EN
        // A decision seen during lockout wins over expiry on the same edge.
        if (res_val) begin
          tmr_d    = LOCKOUT_LD;
          tamper_d = 1'b1;
        end else
`endif
        if (tmr_q == '0) begin
          state_d = LOCKED;
          fail_d  = '0;
        end else begin
          tmr_d   = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  // Output flops load from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LOCKED;
      tmr_q      <= '0;
      fail_q     <= '0;
      solenoid_q <= 1'b0;
      lockout_q  <= 1'b0;
`ifdef SAFE_TAMPER_ALARM_EN
      tamper_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      fail_q     <= fail_d;
      solenoid_q <= (state_d == UNLOCKED);
      lockout_q  <= (state_d == LOCKOUT);
`ifdef SAFE_TAMPER_ALARM_EN
      tamper_q   <= tamper_d;
`endif
    end
  end

  assign solenoid_en = solenoid_q;
  assign lockout     = lockout_q;
  assign fail_cnt    = fail_q;
  assign state_o     = state_q;
`ifdef SAFE_TAMPER_ALARM_EN
  assign tamper      = tamper_q;
`else
  assign tamper      = 1'b0;
`endif

endmodule
